// File: rtl/hwpe_stream_line_sequencer_pkg.sv
// Shared types for the line sequencer: FSM state encoding and the job configuration
// captured at start.
package hwpe_stream_package;

    localparam int unsigned LS_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        LS_IDLE = 2'd0,
        LS_RUN  = 2'd1,
        LS_DONE = 2'd2
    } line_seq_state_t;

    typedef struct packed {
        logic [LS_CNT_WIDTH-1:0] line_length;
        logic [LS_CNT_WIDTH-1:0] nb_lines;
        logic [7:0]              remainder;
    } ctrl_line_seq_t;

endpackage

// File: rtl/hwpe_stream_line_sequencer_if.sv
// HWPE-Stream handshake bundle: the master drives valid/data/strb, the slave drives ready.
interface hwpe_stream_line_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    localparam int unsigned NB_BYTES = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [NB_BYTES-1:0]   strb;

    modport master (output valid, output data, output strb, input  ready);
    modport slave  (input  valid, input  data, input  strb, output ready);

endinterface

// File: rtl/hwpe_stream_line_sequencer_strb_decoder.sv
// Turns a byte count into a low-aligned byte-enable mask; counts at or above the
// word size saturate to all ones.
module hwpe_stream_strb_decoder #(
    parameter int unsigned NB_BYTES = 4
) (
    input  logic [7:0]          remainder_i,
    output logic [NB_BYTES-1:0] mask_o
);

    // Byte i is enabled when it lies below the remainder count
    always_comb begin
        mask_o = {NB_BYTES{1'b0}};
        for (int i = 0; i < NB_BYTES; i++) begin
            if (i < int'(remainder_i)) begin
                mask_o[i] = 1'b1;
            end else begin
                mask_o[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/hwpe_stream_line_sequencer.sv
// Job-level framer: passes a stream through while counting words and lines, trims the
// strobe of each line's last word and pulses done when the job completes.
module hwpe_stream_line_sequencer
    import hwpe_stream_package::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = LS_CNT_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 test_mode_i,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] line_length_i,
    input  logic [CNT_WIDTH-1:0] nb_lines_i,
    input  logic [7:0]           remainder_i,
    hwpe_stream_line_sequencer_if.slave  push_i,
    hwpe_stream_line_sequencer_if.master pop_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 line_end_o
);

    localparam int unsigned          NB_BYTES = DATA_WIDTH / 8;
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam ctrl_line_seq_t       CFG_RST  = ctrl_line_seq_t'({$bits(ctrl_line_seq_t){1'b0}});

    line_seq_state_t      state_q, state_d;
    ctrl_line_seq_t       cfg_q, cfg_d;
    logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
    logic [CNT_WIDTH-1:0] line_len_s, nb_lines_s;
    logic                 run_s, hs_s, last_word_s, last_line_s;
    logic [NB_BYTES-1:0]  mask_s;
    logic                 unused_test_mode_s;

    assign unused_test_mode_s = test_mode_i;

    assign line_len_s  = CNT_WIDTH'(cfg_q.line_length);
    assign nb_lines_s  = CNT_WIDTH'(cfg_q.nb_lines);
    // The zero guards keep the "minus one" from wrapping on an empty configuration
    assign last_word_s = (line_len_s != CNT_ZERO) && (word_cnt_q == line_len_s - CNT_ONE);
    assign last_line_s = (nb_lines_s != CNT_ZERO) && (line_cnt_q == nb_lines_s - CNT_ONE);

    // A clear closes the stream in the same cycle so no beat slips past the abandoned job
    assign run_s = (state_q == LS_RUN) && !clear_i;
    assign hs_s  = run_s && push_i.valid && pop_o.ready;

    assign busy_o     = (state_q != LS_IDLE);
    assign done_o     = (state_q == LS_DONE);
    assign line_end_o = (state_q == LS_RUN) && last_word_s;

    hwpe_stream_strb_decoder #(
        .NB_BYTES (NB_BYTES)
    ) i_strb_decoder (
        .remainder_i (cfg_q.remainder),
        .mask_o      (mask_s)
    );

    // Stream passthrough with handshake gating and last-word strobe trimming
    always_comb begin
        pop_o.valid  = 1'b0;
        push_i.ready = 1'b0;
        pop_o.data   = push_i.data;
        pop_o.strb   = push_i.strb;
        if (run_s) begin
            pop_o.valid  = push_i.valid;
            push_i.ready = pop_o.ready;
        end else begin
            pop_o.valid  = 1'b0;
            push_i.ready = 1'b0;
        end
        if (line_end_o && (cfg_q.remainder != 8'd0)) begin
            pop_o.strb = push_i.strb & mask_s;
        end else begin
            pop_o.strb = push_i.strb;
        end
    end

    // Next-state logic for the FSM, the counters and the configuration register
    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        word_cnt_d = word_cnt_q;
        line_cnt_d = line_cnt_q;
        if (clear_i) begin
            state_d    = LS_IDLE;
            cfg_d      = CFG_RST;
            word_cnt_d = CNT_ZERO;
            line_cnt_d = CNT_ZERO;
        end else begin
            case (state_q)
                LS_IDLE: begin
                    if (start_i) begin
                        cfg_d.line_length = LS_CNT_WIDTH'(line_length_i);
                        cfg_d.nb_lines    = LS_CNT_WIDTH'(nb_lines_i);
                        cfg_d.remainder   = remainder_i;
                        if ((line_length_i == CNT_ZERO) || (nb_lines_i == CNT_ZERO)) begin
                            state_d = LS_DONE;
                        end else begin
                            state_d = LS_RUN;
                        end
                    end else begin
                        state_d = LS_IDLE;
                    end
                end
                LS_RUN: begin
                    if (hs_s) begin
                        if (last_word_s) begin
                            word_cnt_d = CNT_ZERO;
                            if (last_line_s) begin
                                line_cnt_d = CNT_ZERO;
                                state_d    = LS_DONE;
                            end else begin
                                line_cnt_d = line_cnt_q + CNT_ONE;
                            end
                        end else begin
                            word_cnt_d = word_cnt_q + CNT_ONE;
                        end
                    end else begin
                        state_d = LS_RUN;
                    end
                end
                LS_DONE: begin
                    state_d = LS_IDLE;
                end
                default: begin
                    state_d    = LS_IDLE;
                    word_cnt_d = CNT_ZERO;
                    line_cnt_d = CNT_ZERO;
                end
            endcase
        end
    end

    // State, counter and configuration registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= LS_IDLE;
            cfg_q      <= CFG_RST;
            word_cnt_q <= CNT_ZERO;
            line_cnt_q <= CNT_ZERO;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            word_cnt_q <= word_cnt_d;
            line_cnt_q <= line_cnt_d;
        end
    end

endmodule
